// File: rtl/genera_unos_cableada.sv
// Builds a thermometer-coded word with `cuenta` ones, one bit per clock; fin after n+1 cycles.
// Optional macro GENERA_ORDEN_MSB_EN: fill from the MSB side instead of the LSB side.
module genera_unos_cableada #(
    parameter int WIDTH = 3,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CW-1:0]    cuenta,
    output logic [WIDTH-1:0] valor,
    output logic             fin,
    output logic             ocupado,
    output logic             error
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_t;

    estado_t          estado_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] valor_q;
    logic             fin_q;
    logic             ocupado_q;
    logic             error_q;

    logic [WIDTH-1:0] valor_d;
    logic             excede_d;
    logic [CW-1:0]    cnt_d;

`ifdef GENERA_ORDEN_MSB_EN
    assign valor_d = {1'b1, valor_q[WIDTH-1:1]};
`else
    assign valor_d = {valor_q[WIDTH-2:0], 1'b1};
`endif

    // Requests larger than the word are clamped so the run still terminates.
    assign excede_d = (cuenta > CW'(WIDTH));
    assign cnt_d    = excede_d ? CW'(WIDTH) : cuenta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            valor_q   <= '0;
            fin_q     <= 1'b0;
            ocupado_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (estado_q)
                REPOSO, FIN: begin
                    if (start) begin
                        estado_q  <= DESPLAZA;
                        cnt_q     <= cnt_d;
                        valor_q   <= '0;
                        fin_q     <= 1'b0;
                        ocupado_q <= 1'b1;
                        error_q   <= excede_d;
                    end
                end
                DESPLAZA: begin
                    if (cnt_q != '0) begin
                        valor_q <= valor_d;
                        cnt_q   <= cnt_q - CW'(1);
                    end else begin
                        estado_q  <= FIN;
                        fin_q     <= 1'b1;
                        ocupado_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q  <= REPOSO;
                    cnt_q     <= '0;
                    valor_q   <= '0;
                    fin_q     <= 1'b0;
                    ocupado_q <= 1'b0;
                    error_q   <= 1'b0;
                end
            endcase
        end
    end

    assign valor   = valor_q;
    assign fin     = fin_q;
    assign ocupado = ocupado_q;
    assign error   = error_q;

endmodule

// File: tb/tb_genera_unos_cableada.sv
// Directed bench for genera_unos_cableada (WIDTH=3, CW=4); honours GENERA_ORDEN_MSB_EN.
module tb_genera_unos_cableada;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] cuenta;
    logic [2:0] valor;
    logic       fin;
    logic       ocupado;
    logic       error;

    int checks = 0;
    int errors = 0;

    genera_unos_cableada #(.WIDTH(3), .CW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .cuenta  (cuenta),
        .valor   (valor),
        .fin     (fin),
        .ocupado (ocupado),
        .error   (error)
    );

    always #5 clk = ~clk;

    // Expected word after n insertions.
    function automatic logic [2:0] fill(input int n);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < n; i++) begin
`ifdef GENERA_ORDEN_MSB_EN
            r = {1'b1, r[2:1]};
`else
            r = {r[1:0], 1'b1};
`endif
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] v, input logic f,
                           input logic o, input logic e);
        chk({tag, ".valor"}, 32'(valor), 32'(v));
        chk({tag, ".fin"}, 32'(fin), 32'(f));
        chk({tag, ".ocupado"}, 32'(ocupado), 32'(o));
        chk({tag, ".error"}, 32'(error), 32'(e));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b1;
        cuenta  = 4'd3;

        // Reset holds everything cleared despite start.
        edge_step();
        chk_all("rst0", 3'b000, 1'b0, 1'b0, 1'b0);
        edge_step();
        chk_all("rst1", 3'b000, 1'b0, 1'b0, 1'b0);

        // Full word, start pulse at edge k.
        reset_n = 1'b1;
        edge_step();
        chk_all("full_k", 3'b000, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            edge_step();
            chk_all($sformatf("full_k%0d", i), fill(i), 1'b0, 1'b1, 1'b0);
        end
        edge_step();
        chk_all("full_fin", 3'b111, 1'b1, 1'b0, 1'b0);
        chk("full_roundtrip", 32'($countones(valor)), 32'd3);
        edge_step();
        chk_all("full_hold", 3'b111, 1'b1, 1'b0, 1'b0);

        // Zero count restarts from FIN.
        cuenta = 4'd0;
        start  = 1'b1;
        edge_step();
        chk_all("zero_k", 3'b000, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        edge_step();
        chk_all("zero_fin", 3'b000, 1'b1, 1'b0, 1'b0);

        // Clamped request.
        cuenta = 4'b1001;
        start  = 1'b1;
        edge_step();
        chk_all("clamp_k", 3'b000, 1'b0, 1'b1, 1'b1);
        start = 1'b0;
        edge_step();
        edge_step();
        edge_step();
        chk_all("clamp_k3", 3'b111, 1'b0, 1'b1, 1'b1);
        edge_step();
        chk_all("clamp_fin", 3'b111, 1'b1, 1'b0, 1'b1);

        // Following legal load clears error.
        cuenta = 4'd2;
        start  = 1'b1;
        edge_step();
        chk_all("two_k", 3'b000, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        edge_step();
        chk_all("two_k1", fill(1), 1'b0, 1'b1, 1'b0);
        edge_step();
        chk_all("two_k2", fill(2), 1'b0, 1'b1, 1'b0);
        edge_step();
        chk_all("two_fin", fill(2), 1'b1, 1'b0, 1'b0);

        // start/cuenta changes during DESPLAZA are ignored.
        cuenta = 4'd3;
        start  = 1'b1;
        edge_step();
        start  = 1'b0;
        cuenta = 4'd1;
        edge_step();
        start = 1'b1;
        edge_step();
        start = 1'b0;
        edge_step();
        chk_all("busy_k3", 3'b111, 1'b0, 1'b1, 1'b0);
        edge_step();
        chk_all("busy_fin", 3'b111, 1'b1, 1'b0, 1'b0);

        // Reset mid-run aborts and clears a latched error.
        cuenta = 4'd9;
        start  = 1'b1;
        edge_step();
        chk_all("abort_k", 3'b000, 1'b0, 1'b1, 1'b1);
        start = 1'b0;
        edge_step();
        chk_all("abort_k1", fill(1), 1'b0, 1'b1, 1'b1);
        reset_n = 1'b0;
        edge_step();
        chk_all("abort_rst", 3'b000, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        edge_step();
        chk_all("abort_idle", 3'b000, 1'b0, 1'b0, 1'b0);
        edge_step();
        chk_all("abort_idle2", 3'b000, 1'b0, 1'b0, 1'b0);

        // Held start re-triggers on the edge after fin.
        cuenta = 4'd1;
        start  = 1'b1;
        edge_step();
        chk_all("retrig_k", 3'b000, 1'b0, 1'b1, 1'b0);
        edge_step();
        chk_all("retrig_k1", fill(1), 1'b0, 1'b1, 1'b0);
        edge_step();
        chk_all("retrig_fin", fill(1), 1'b1, 1'b0, 1'b0);
        edge_step();
        chk_all("retrig_again", 3'b000, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        edge_step();
        edge_step();
        chk_all("retrig_fin2", fill(1), 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
